tag_mem_arb: RTL and testbench
==============================

Name: tag_mem_arb

Overview:
- Parametrised, register-based tag memory. Successor to the fixed 64x16 single-port register ROM used beside the tag digital core.
- Adds configurable width and depth, NUM_CH requester channels with round-robin arbitration, and a write path.
- Adds a sticky write-lock over a protected low region (EPC/key area) and error reporting.
- Sits between the digital core's sub-units (protocol engine, crypto engine, test logic) and the storage.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- NUM_CH, 2, number of requester channels, range 1..8.
- LOCK_DEPTH, 16, words 0..LOCK_DEPTH-1 become read-only once locked.
- INIT_VAL, 0, value of every word after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel grant; combinational from req_valid and the priority pointer.
- req_we  in  NUM_CH  1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- rsp_valid  out  1  one-cycle response strobe.
- rsp_ch  out  max(1,clog2(NUM_CH))  index of the channel being answered.
- rsp_data  out  DATA_W  read data, or the data written for a write.
- rsp_err  out  1  request rejected.
- i_lock  in  1  lock request pulse.
- o_locked  out  1  lock status.

Behaviour:
- Reset (async, rst=1):
  - all words = INIT_VAL; rsp_valid = 0; rsp_ch = 0; rsp_data = 0; rsp_err = 0; o_locked = 0.
  - Priority pointer = 0.
  - Any in-flight response is dropped; no partial write.
- Arbitration:
  - Round-robin, at most one grant per cycle.
  - Search starts at the pointer and wraps modulo NUM_CH.
  - req_ready[i] = 1 only for the granted channel.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - After a grant to channel g, the pointer becomes (g+1) mod NUM_CH.
  - With no valid request, no grant is issued and the pointer holds.
  - Requesters keep request fields stable until granted.
- Latency:
  - The response appears exactly one cycle after the transfer cycle: rsp_valid=1 for one cycle with rsp_ch = granted index.
  - rsp_valid=0 in all other cycles; rsp_data and rsp_err hold their last values.
- Read:
  - rsp_data = mem[addr] as of the transfer cycle; rsp_err = 0.
- Write:
  - mem[addr] <= wdata at the transfer edge; rsp_data = wdata; rsp_err = 0.
  - A read granted in the next cycle to the same address returns the new data.
- Lock:
  - i_lock=1 sets o_locked at the next edge. It is sticky until reset.
  - A write to addr < LOCK_DEPTH while o_locked=1 leaves memory unchanged; rsp_err = 1, rsp_data = current mem[addr].
  - A write transferred in the same cycle as the i_lock pulse still completes, because the lock takes effect next cycle.
  - Reads are never blocked.
- Width rules:
  - The address is unsigned and DEPTH is a power of two, so there is no out-of-range case.
  - LOCK_DEPTH=0 disables protection; LOCK_DEPTH >= DEPTH protects all words.
- NUM_CH=1: the arbiter degenerates to req_ready = req_valid; rsp_ch is constantly 0.

Decomposition:
- Shared package tag_mem_pkg holds:
  - the ch_idx width function clog2;
  - response-type constants RSP_OK and RSP_ERR;
  - default INIT_VAL and LOCK_DEPTH for the current tag generation.
- One sub-module, tag_rr_arbiter (parameter NUM_CH):
  - inputs: req vector, advance strobe;
  - outputs: one-hot grant and binary index;
  - owns the priority pointer.
- Memory array, lock flag and response register stay in tag_mem_arb.

Test Plan:
1. Reset then read: rst pulse with INIT_VAL=0; ch0 reads addr 5 -> next cycle rsp_valid=1, rsp_ch=0, rsp_data=0x0000, rsp_err=0.
2. Write then immediate read: ch1 writes 0xBEEF to addr 40, then reads addr 40 in the next cycle -> responses rsp_data=0xBEEF twice on consecutive cycles, both rsp_ch=1.
3. Fairness: ch0 and ch1 both hold valid for 4 cycles -> grants alternate 0,1,0,1; response rsp_ch sequence 0,1,0,1.
4. Lock:
   - ch0 writes 0x1234 to addr 3; pulse i_lock; ch0 writes 0xFFFF to addr 3 -> second response rsp_err=1, rsp_data=0x1234.
   - A subsequent write 0xFFFF to addr 20 -> rsp_err=0.
5. Lock race: i_lock pulse in the same cycle as a write of 0x00AA to addr 2 -> write succeeds (rsp_err=0); the next write to addr 2 -> rsp_err=1.
6. Reset mid-operation: assert rst in the cycle after a transfer -> rsp_valid stays 0, o_locked=0, addr 40 reads back INIT_VAL, pointer restarts at ch0.

Source files
------------

// File: rtl/tag_mem_pkg.sv
// Shared definitions for the tag memory: channel-index width helper,
// response status codes and the defaults for the current tag generation.
package tag_mem_pkg;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    localparam int DEF_INIT_VAL   = 0;
    localparam int DEF_LOCK_DEPTH = 16;

    // Width of a channel index; never below 1 so NUM_CH=1 still has a port.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tag_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starting at the priority
// pointer; the pointer moves past the winner whenever a transfer occurs.
module tag_rr_arbiter
    import tag_mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int IDX_W = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic [IDX_W-1:0]  o_ptr
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_CH);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= IDX_W'((int'(o_idx) + 1) % NUM_CH);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/tag_mem_arb.sv
// Register-based tag memory shared by NUM_CH requesters through a round-robin
// arbiter, with a sticky write-lock over the low LOCK_DEPTH words.
module tag_mem_arb
    import tag_mem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 6,
    parameter int NUM_CH     = 2,
    parameter int LOCK_DEPTH = DEF_LOCK_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEF_INIT_VAL),
    localparam int DEPTH     = 2 ** ADDR_W,
    localparam int IDX_W     = clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic                     rsp_valid,
    output logic [IDX_W-1:0]         rsp_ch,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    input  logic                     i_lock,
    output logic                     o_locked
);

    // Handshake: a transfer happens on a rising edge where req_valid[i] and
    // req_ready[i] are both high; the requester holds we/addr/wdata stable
    // until then. The response strobe rsp_valid follows exactly one cycle later.

    logic [NUM_CH-1:0] w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_ptr;
    logic              w_xfer;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_prot;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_locked;

    tag_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req_valid),
        .i_advance (w_xfer),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_ptr     (w_ptr)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;
    assign w_we      = req_we[w_idx];
    assign w_addr    = req_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_wdata   = req_wdata[w_idx*DATA_W +: DATA_W];
    // The lock flag is registered, so a write in the i_lock cycle still lands.
    assign w_prot    = r_locked && (int'(w_addr) < LOCK_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_VAL;
            r_locked  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_ch    <= '0;
            rsp_data  <= '0;
            rsp_err   <= RSP_OK;
        end else begin
            if (i_lock) r_locked <= 1'b1;
            rsp_valid <= w_xfer;
            if (w_xfer) begin
                rsp_ch <= w_idx;
                if (w_we && !w_prot) begin
                    r_mem[w_addr] <= w_wdata;
                    rsp_data      <= w_wdata;
                    rsp_err       <= RSP_OK;
                end else begin
                    rsp_data <= r_mem[w_addr];
                    rsp_err  <= (w_we && w_prot) ? RSP_ERR : RSP_OK;
                end
            end
        end
    end

    assign o_locked = r_locked;

    logic w_unused;
    assign w_unused = ^w_ptr;

endmodule

// File: tb/tb_tag_mem_arb.sv
// Directed self-checking bench for tag_mem_arb with two channels.
module tb_tag_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [0:0]  rsp_ch;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        i_lock = 1'b0;
    logic        o_locked;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    tag_mem_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .i_lock    (i_lock),
        .o_locked  (o_locked)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    // Driver tasks
    task automatic set_req(input int ch, input logic we, input logic [5:0] addr,
                           input logic [15:0] wd);
        req_valid[ch]          = 1'b1;
        req_we[ch]             = we;
        req_addr[ch*6 +: 6]    = addr;
        req_wdata[ch*16 +: 16] = wd;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic check_rsp(input string tag, input logic ch, input logic [15:0] data,
                             input logic err);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_ch"},    32'(rsp_ch),    32'(ch));
        check({tag, "_data"},  32'(rsp_data),  32'(data));
        check({tag, "_err"},   32'(rsp_err),   32'(err));
    endtask

    initial begin
        step();
        step();
        check("rst_valid",  32'(rsp_valid), 32'd0);
        check("rst_data",   32'(rsp_data),  32'd0);
        check("rst_err",    32'(rsp_err),   32'd0);
        check("rst_locked", 32'(o_locked),  32'd0);
        rst = 1'b0;

        // 1: read after reset
        set_req(0, 1'b0, 6'd5, 16'h0);
        #1 check("t1_ready", 32'(req_ready), 32'b01);
        step();
        clr_req();
        check_rsp("t1", 1'b0, 16'h0000, 1'b0);
        step();
        check("t1_idle", 32'(rsp_valid), 32'd0);

        // 2: write then immediate read on ch1
        set_req(1, 1'b1, 6'd40, 16'hBEEF);
        #1 check("t2_ready", 32'(req_ready), 32'b10);
        step();
        set_req(1, 1'b0, 6'd40, 16'h0);
        check_rsp("t2_wr", 1'b1, 16'hBEEF, 1'b0);
        step();
        clr_req();
        check_rsp("t2_rd", 1'b1, 16'hBEEF, 1'b0);
        step();

        // 3: fairness with both channels requesting
        set_req(0, 1'b0, 6'd0, 16'h0);
        set_req(1, 1'b0, 6'd1, 16'h0);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k % 2));
        for (int k = 0; k < 4; k++) begin
            #1 check("t3_ready", 32'(req_ready), 32'(1 << (k % 2)));
            step();
            if (k == 3) clr_req();
            check("t3_rsp_ch", 32'(rsp_ch), exp_q.pop_front());
        end
        step();

        // 4: lock blocks writes to the protected region only
        set_req(0, 1'b1, 6'd3, 16'h1234);
        step();
        clr_req();
        check_rsp("t4_wr", 1'b0, 16'h1234, 1'b0);
        i_lock = 1'b1;
        step();
        i_lock = 1'b0;
        check("t4_locked", 32'(o_locked), 32'd1);
        set_req(0, 1'b1, 6'd3, 16'hFFFF);
        #1 check("t4_ready", 32'(req_ready), 32'b01);
        step();
        set_req(0, 1'b1, 6'd20, 16'hFFFF);
        check_rsp("t4_prot", 1'b0, 16'h1234, 1'b1);
        step();
        set_req(0, 1'b0, 6'd3, 16'h0);
        check_rsp("t4_open", 1'b0, 16'hFFFF, 1'b0);
        step();
        clr_req();
        check_rsp("t4_rd3", 1'b0, 16'h1234, 1'b0);
        step();

        // 6: reset right after a transfer
        set_req(0, 1'b1, 6'd40, 16'h5555);
        step();
        clr_req();
        rst = 1'b1;
        #1;
        check("t6_valid",  32'(rsp_valid), 32'd0);
        check("t6_locked", 32'(o_locked),  32'd0);
        step();
        rst = 1'b0;
        set_req(0, 1'b0, 6'd40, 16'h0);
        set_req(1, 1'b0, 6'd40, 16'h0);
        #1 check("t6_ptr", 32'(req_ready), 32'b01);
        step();
        clr_req();
        check_rsp("t6_rd", 1'b0, 16'h0000, 1'b0);
        step();

        // 5: lock pulse coinciding with a write
        set_req(0, 1'b1, 6'd2, 16'h00AA);
        i_lock = 1'b1;
        step();
        i_lock = 1'b0;
        set_req(0, 1'b1, 6'd2, 16'h0055);
        check_rsp("t5_race", 1'b0, 16'h00AA, 1'b0);
        check("t5_locked", 32'(o_locked), 32'd1);
        step();
        clr_req();
        check_rsp("t5_prot", 1'b0, 16'h00AA, 1'b1);
        step();
        check("t5_idle", 32'(rsp_valid), 32'd0);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
